// File: rtl/fuzzy_infer_seq_if.sv
// Start/done job bus of the fuzzy inference sequencer: latched operands in, results out.
interface fuzzy_infer_seq_if;
    logic        start;
    logic [47:0] mu_t;
    logic [47:0] mu_d;
    logic        reg_mode;
    logic [71:0] g_flat;
    logic        busy;
    logic        done;
    logic [7:0]  G_out;
    logic [15:0] S_w;
    logic [15:0] S_wg;

    modport master (
        output start, mu_t, mu_d, reg_mode, g_flat,
        input  busy, done, G_out, S_w, S_wg
    );

    modport slave (
        input  start, mu_t, mu_d, reg_mode, g_flat,
        output busy, done, G_out, S_w, S_wg
    );
endinterface

// File: rtl/fuzzy_infer_seq.sv
// Time-multiplexed 3x3 fuzzy inference: one rule per cycle, then an 8-step restoring divider.
// Optional FUZZY_SEQ_ROUND_EN adds a half-divisor bias so the output rounds half up instead of flooring.
module fuzzy_infer_seq (
    input  logic              clk,
    input  logic              rst,
    fuzzy_infer_seq_if.slave  s_bus
);
    localparam int unsigned N_RULES   = 9;
    localparam int unsigned ACC_W     = 20;
    localparam int unsigned DIV_STEPS = 8;
    localparam int unsigned MU_W      = 16;
    localparam int unsigned G_W       = 8;
    localparam int unsigned DVD_W     = ACC_W + 8;

    typedef enum logic [1:0] {IDLE, RULE, DIV} state_t;

    state_t                r_state;
    logic [3*MU_W-1:0]     r_mu_t;
    logic [3*MU_W-1:0]     r_mu_d;
    logic [9*G_W-1:0]      r_g;
    logic                  r_mode;
    logic [3:0]            r_k;
    logic [ACC_W-1:0]      r_acc_w;
    logic [ACC_W-1:0]      r_acc_wg;
    logic [DVD_W-1:0]      r_rem;
    logic [DVD_W-1:0]      r_dsor;
    logic [7:0]            r_q;
    logic [2:0]            r_step;

    logic [1:0]            w_ti;
    logic [1:0]            w_dj;
    logic                  w_corner;
    logic [MU_W-1:0]       w_mt;
    logic [MU_W-1:0]       w_md;
    logic [MU_W-1:0]       w_w;
    logic [G_W-1:0]        w_g;
    logic [23:0]           w_gnum;
    logic [23:0]           w_gdiv;
    logic [14:0]           w_gq;
    logic [31:0]           w_prod;
    logic [MU_W-1:0]       w_wg;
    logic [ACC_W-1:0]      w_acc_w_nxt;
    logic [ACC_W-1:0]      w_acc_wg_nxt;
    logic [DVD_W-1:0]      w_bias;
    logic [DVD_W-1:0]      w_dividend;
    logic                  w_ge;
    logic [7:0]            w_q_full;
    logic [7:0]            w_q_sel;

    // Rule index k = 3*i + j mapped to membership selectors and the corner mask.
    always_comb begin
        w_ti     = 2'd0;
        w_dj     = 2'd0;
        w_corner = 1'b0;
        unique case (r_k)
            4'd0: begin w_ti = 2'd0; w_dj = 2'd0; w_corner = 1'b1; end
            4'd1: begin w_ti = 2'd0; w_dj = 2'd1; end
            4'd2: begin w_ti = 2'd0; w_dj = 2'd2; w_corner = 1'b1; end
            4'd3: begin w_ti = 2'd1; w_dj = 2'd0; end
            4'd4: begin w_ti = 2'd1; w_dj = 2'd1; end
            4'd5: begin w_ti = 2'd1; w_dj = 2'd2; end
            4'd6: begin w_ti = 2'd2; w_dj = 2'd0; w_corner = 1'b1; end
            4'd7: begin w_ti = 2'd2; w_dj = 2'd1; end
            4'd8: begin w_ti = 2'd2; w_dj = 2'd2; w_corner = 1'b1; end
            default: begin w_ti = 2'd0; w_dj = 2'd0; w_corner = 1'b0; end
        endcase
    end

    always_comb begin
        w_mt = r_mu_t[MU_W-1:0];
        w_md = r_mu_d[MU_W-1:0];
        unique case (w_ti)
            2'd1:    w_mt = r_mu_t[2*MU_W-1:MU_W];
            2'd2:    w_mt = r_mu_t[3*MU_W-1:2*MU_W];
            default: w_mt = r_mu_t[MU_W-1:0];
        endcase
        unique case (w_dj)
            2'd1:    w_md = r_mu_d[2*MU_W-1:MU_W];
            2'd2:    w_md = r_mu_d[3*MU_W-1:2*MU_W];
            default: w_md = r_mu_d[MU_W-1:0];
        endcase
    end

    // Rule firing strength, gain scaled to Q1.15 (gains above 100 saturate via the min), weighted term.
    assign w_w          = (r_mode || w_corner) ? ((w_mt < w_md) ? w_mt : w_md) : MU_W'(0);
    assign w_g          = r_g[{r_k, 3'b000} +: G_W];
    assign w_gnum       = 24'(w_g) * 24'd32767 + 24'd50;
    assign w_gdiv       = w_gnum / 24'd100;
    assign w_gq         = (w_gdiv > 24'd32767) ? 15'd32767 : w_gdiv[14:0];
    assign w_prod       = 32'(w_w) * 32'(w_gq) + 32'd16384;
    assign w_wg         = MU_W'(w_prod >> 15);
    assign w_acc_w_nxt  = r_acc_w + ACC_W'(w_w);
    assign w_acc_wg_nxt = r_acc_wg + ACC_W'(w_wg);

`ifdef FUZZY_SEQ_ROUND_EN
    assign w_bias = DVD_W'(w_acc_w_nxt >> 1);
`else
    assign w_bias = DVD_W'(0);
`endif

    assign w_dividend = DVD_W'(w_acc_wg_nxt) * DVD_W'(100) + w_bias;

    // Quotient is at most 100, so 8 MSB-first trial subtractions of divisor<<b suffice.
    assign w_ge     = (r_rem >= r_dsor);
    assign w_q_full = {r_q[6:0], w_ge};
    assign w_q_sel  = (r_acc_w == ACC_W'(0)) ? 8'd0 : w_q_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mu_t      <= '0;
            r_mu_d      <= '0;
            r_g         <= '0;
            r_mode      <= 1'b0;
            r_k         <= '0;
            r_acc_w     <= '0;
            r_acc_wg    <= '0;
            r_rem       <= '0;
            r_dsor      <= '0;
            r_q         <= '0;
            r_step      <= '0;
            s_bus.busy  <= 1'b0;
            s_bus.done  <= 1'b0;
            s_bus.G_out <= '0;
            s_bus.S_w   <= '0;
            s_bus.S_wg  <= '0;
        end else begin
            s_bus.done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (s_bus.start) begin
                        r_mu_t     <= s_bus.mu_t;
                        r_mu_d     <= s_bus.mu_d;
                        r_g        <= s_bus.g_flat;
                        r_mode     <= s_bus.reg_mode;
                        r_acc_w    <= '0;
                        r_acc_wg   <= '0;
                        r_k        <= '0;
                        s_bus.busy <= 1'b1;
                        r_state    <= RULE;
                    end
                end
                RULE: begin
                    r_acc_w  <= w_acc_w_nxt;
                    r_acc_wg <= w_acc_wg_nxt;
                    if (r_k == 4'(N_RULES - 1)) begin
                        r_rem   <= w_dividend;
                        r_dsor  <= DVD_W'(w_acc_w_nxt) << 7;
                        r_q     <= '0;
                        r_step  <= '0;
                        r_state <= DIV;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                DIV: begin
                    if (w_ge) r_rem <= r_rem - r_dsor;
                    r_dsor <= r_dsor >> 1;
                    r_q    <= w_q_full;
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'(DIV_STEPS - 1)) begin
                        s_bus.G_out <= (w_q_sel > 8'd100) ? 8'd100 : w_q_sel;
                        s_bus.S_w   <= (|r_acc_w[ACC_W-1:16])  ? 16'hFFFF : r_acc_w[15:0];
                        s_bus.S_wg  <= (|r_acc_wg[ACC_W-1:16]) ? 16'hFFFF : r_acc_wg[15:0];
                        s_bus.done  <= 1'b1;
                        s_bus.busy  <= 1'b0;
                        r_k         <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
